multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 126 ++++++++++++
 tb/tb_multicycle_alu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multicycle 32-bit ALU: single-cycle logic/arith/compare ops, shifts performed
// one bit per cycle, valid/ready handshakes on both request and result sides.
module multicycle_alu (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  Operation,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] ALUResult
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_EQ   = 4'b1000;
   localparam logic [3:0] OP_GE   = 4'b1001;
   localparam logic [3:0] OP_NE   = 4'b1010;
   localparam logic [3:0] OP_LT   = 4'b1100;
   localparam logic [3:0] OP_PASS = 4'b1101;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_op;
   logic [31:0] r_work;
   logic [4:0]  r_cnt;
   logic [31:0] r_result;
   logic        w_accept;
   logic        w_is_shift;
   logic        w_start_shift;

   // Shift codes only reach here with a zero shift amount, so they pass SrcA.
   function automatic logic [31:0] alu_single(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      case (op)
         OP_AND:  alu_single = a & b;
         OP_OR:   alu_single = a | b;
         OP_ADD:  alu_single = a + b;
         OP_XOR:  alu_single = a ^ b;
         OP_SUB:  alu_single = a - b;
         OP_SLL, OP_SRL, OP_SRA: alu_single = a;
         OP_EQ:   alu_single = {31'd0, a == b};
         OP_GE:   alu_single = {31'd0, sa >= sb};
         OP_NE:   alu_single = {31'd0, a != b};
         OP_LT:   alu_single = {31'd0, sa < sb};
         OP_PASS: alu_single = 32'd1;
         default: alu_single = 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] shift_one(input logic [3:0] op,
                                             input logic [31:0] v);
      case (op)
         OP_SLL:  shift_one = {v[30:0], 1'b0};
         OP_SRL:  shift_one = {1'b0, v[31:1]};
         OP_SRA:  shift_one = {v[31], v[31:1]};
         default: shift_one = v;
      endcase
   endfunction

   assign in_ready      = (r_state == IDLE);
   assign out_valid     = (r_state == DONE);
   assign ALUResult     = r_result;
   assign w_accept      = in_valid && in_ready;
   assign w_is_shift    = (Operation == OP_SLL) || (Operation == OP_SRL) ||
                          (Operation == OP_SRA);
   assign w_start_shift = w_is_shift && (SrcB[4:0] != 5'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = w_start_shift ? SHIFT : DONE;
         // The edge performing the final shift also enters DONE.
         SHIFT:   if (r_cnt == 5'd1) w_next_state = DONE;
         DONE:    if (out_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op     <= 4'd0;
         r_work   <= 32'd0;
         r_cnt    <= 5'd0;
         r_result <= 32'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op   <= Operation;
                  r_work <= SrcA;
                  if (w_start_shift) r_cnt <= SrcB[4:0];
                  else               r_result <= alu_single(Operation, SrcA, SrcB);
               end
            end
            SHIFT: begin
               r_work <= shift_one(r_op, r_work);
               r_cnt  <= r_cnt - 5'd1;
               if (r_cnt == 5'd1) r_result <= shift_one(r_op, r_work);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu: latency, results, handshakes,
// backpressure and reset abort, with hand-computed expectations.
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multicycle_alu dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 64) begin
         tick();
         lat++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      Operation = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (ALUResult !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", ALUResult); end
      reset = 1'b0;
   endtask

   task automatic test_add();
      int lat;
      send(4'b0010, 32'hFFFFFFFF, 32'd1);
      wait_valid(lat);
      checks++;
      if (lat != 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", lat); end
      checks++;
      if (ALUResult !== 32'h0) begin errors++; $display("FAIL add_result: got %h expected 00000000", ALUResult); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL add_in_ready_done: got %b expected 0", in_ready); end
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL add_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_sra();
      int lat;
      logic bad_ready;
      send(4'b0111, 32'h80000000, 32'd4);
      Operation = 4'b0000; SrcA = 32'h0; SrcB = 32'h0;
      lat = 1;
      bad_ready = 1'b0;
      while (out_valid !== 1'b1 && lat < 64) begin
         if (in_ready !== 1'b0) bad_ready = 1'b1;
         tick();
         lat++;
      end
      checks++;
      if (lat != 5) begin errors++; $display("FAIL sra_latency: got %0d expected 5", lat); end
      checks++;
      if (ALUResult !== 32'hF8000000) begin errors++; $display("FAIL sra_result: got %h expected f8000000", ALUResult); end
      checks++;
      if (bad_ready !== 1'b0) begin errors++; $display("FAIL sra_in_ready_busy: got 1 expected 0"); end
      handshake();
   endtask

   task automatic test_shifts();
      int lat;
      send(4'b0100, 32'd1, 32'h0000001F);
      wait_valid(lat);
      checks++;
      if (lat != 32 || ALUResult !== 32'h80000000) begin
         errors++; $display("FAIL sll31: got lat=%0d res=%h expected lat=32 res=80000000", lat, ALUResult);
      end
      handshake();
      send(4'b0101, 32'h80000000, 32'hFFFFFFFF);
      wait_valid(lat);
      checks++;
      if (lat != 32 || ALUResult !== 32'h00000001) begin
         errors++; $display("FAIL srl31_upper_ignored: got lat=%0d res=%h expected lat=32 res=00000001", lat, ALUResult);
      end
      handshake();
   endtask

   task automatic test_compares();
      logic [3:0]  ops [8];
      logic [31:0] as  [8];
      logic [31:0] bs  [8];
      logic [31:0] exp [8];
      int lat;
      ops = '{4'b1100, 4'b1001, 4'b1010, 4'b1000, 4'b1101, 4'b0110, 4'b0001, 4'b0011};
      as  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'h0, 32'h0, 32'h000000F0, 32'hFF00FF00};
      bs  = '{32'd1, 32'd1, 32'd7, 32'd7, 32'h0, 32'd1, 32'h0000000F, 32'h0FF00FF0};
      exp = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'hFFFFFFFF, 32'h000000FF, 32'hF0F0F0F0};
      for (int i = 0; i < 8; i++) begin
         send(ops[i], as[i], bs[i]);
         wait_valid(lat);
         checks++;
         if (lat != 1 || ALUResult !== exp[i]) begin
            errors++;
            $display("FAIL op_%b: got lat=%0d res=%h expected lat=1 res=%h", ops[i], lat, ALUResult, exp[i]);
         end
         handshake();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic unstable;
      send(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00);
      wait_valid(lat);
      unstable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (out_valid !== 1'b1 || ALUResult !== 32'hF000F000) unstable = 1'b1;
      end
      checks++;
      if (unstable !== 1'b0) begin
         errors++; $display("FAIL bp_hold: got out_valid=%b res=%h expected 1/f000f000", out_valid, ALUResult);
      end
      // A request waiting during the result handshake must not be taken on that edge.
      Operation = 4'b0010; SrcA = 32'd5; SrcB = 32'd6; in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || ALUResult !== 32'd11) begin
         errors++; $display("FAIL bp_next_accept: got out_valid=%b res=%h expected 1/0000000b", out_valid, ALUResult);
      end
      handshake();
   endtask

   task automatic test_reset_abort();
      int lat;
      send(4'b0100, 32'd1, 32'd20);
      for (int i = 0; i < 5; i++) tick();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || ALUResult !== 32'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_async: got out_valid=%b res=%h in_ready=%b expected 0/00000000/1", out_valid, ALUResult, in_ready);
      end
      tick();
      reset = 1'b0;
      send(4'b0000, 32'h0000FFFF, 32'h00FF00FF);
      wait_valid(lat);
      checks++;
      if (lat != 1 || ALUResult !== 32'h000000FF) begin
         errors++; $display("FAIL abort_then_and: got lat=%0d res=%h expected lat=1 res=000000ff", lat, ALUResult);
      end
      handshake();
   endtask

   task automatic test_edge_cases();
      int lat;
      send(4'b0100, 32'h00001234, 32'h00000020);
      wait_valid(lat);
      checks++;
      if (lat != 1 || ALUResult !== 32'h00001234) begin
         errors++; $display("FAIL sll0: got lat=%0d res=%h expected lat=1 res=00001234", lat, ALUResult);
      end
      handshake();
      send(4'b1111, 32'd5, 32'd5);
      wait_valid(lat);
      checks++;
      if (lat != 1 || ALUResult !== 32'd0) begin
         errors++; $display("FAIL undef_1111: got lat=%0d res=%h expected lat=1 res=00000000", lat, ALUResult);
      end
      handshake();
      send(4'b0001, 32'h0000000A, 32'h00000005);
      wait_valid(lat);
      handshake();
      send(4'b1011, 32'd3, 32'd3);
      wait_valid(lat);
      checks++;
      if (lat != 1 || ALUResult !== 32'd0) begin
         errors++; $display("FAIL undef_1011: got lat=%0d res=%h expected lat=1 res=00000000", lat, ALUResult);
      end
      handshake();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sra();
      test_shifts();
      test_compares();
      test_backpressure();
      test_reset_abort();
      test_edge_cases();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
